// File: rtl/dds_frame_parser.sv
// Byte-stream to command-frame parser for the DDS controller register-access path.
// Assembles 8-byte frames (SYNC OP ADDR D3..D0 CSUM), validates them and issues one command.
module dds_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter int unsigned TO_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        err_pulse,
    output logic [1:0]  err_code,
    output logic [7:0]  ok_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [3:0] {
        StHunt, StOp, StAddr, StD3, StD2, StD1, StD0, StCsum, StIssue
    } state_t;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [7:0]      op_sh;
    logic [7:0]      addr_sh;
    logic [31:0]     data_sh;
    logic [TO_W-1:0] to_cnt;

    logic       accept;
    logic       in_frame;
    logic [7:0] csum_calc;
    logic       op_ok;
    logic       timeout;
    logic       csum_err;
    logic       op_err;

    assign byte_ready = (state != StIssue);
    assign accept     = byte_valid && byte_ready;
    assign in_frame   = (state != StHunt) && (state != StIssue);
    assign csum_calc  = op_sh ^ addr_sh ^ data_sh[31:24] ^ data_sh[23:16] ^ data_sh[15:8]
                        ^ data_sh[7:0];
    assign op_ok      = (op_sh == 8'h01) || (op_sh == 8'h02);
    // An accepted byte in the expiry cycle wins over the timeout.
    assign timeout    = in_frame && !accept && (to_cnt == ToLast);
    assign csum_err   = (state == StCsum) && accept && (byte_data != csum_calc);
    assign op_err     = (state == StCsum) && accept && (byte_data == csum_calc) && !op_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StHunt;
            op_sh     <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
            to_cnt    <= '0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_frame) begin
                to_cnt <= accept ? '0 : to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            if (timeout || csum_err || op_err) begin
                state     <= StHunt;
                to_cnt    <= '0;
                err_pulse <= 1'b1;
                err_cnt   <= err_cnt + 8'd1;
                err_code  <= csum_err ? 2'b01 : (timeout ? 2'b10 : 2'b11);
            end else begin
                case (state)
                    StHunt: begin
                        if (accept && byte_data == SYNC_BYTE) state <= StOp;
                    end
                    StOp: begin
                        if (accept) begin
                            op_sh <= byte_data;
                            state <= StAddr;
                        end
                    end
                    StAddr: begin
                        if (accept) begin
                            addr_sh <= byte_data;
                            state   <= StD3;
                        end
                    end
                    StD3, StD2, StD1, StD0: begin
                        if (accept) begin
                            data_sh <= {data_sh[23:0], byte_data};
                            state   <= state_t'(state + 4'd1);
                        end
                    end
                    StCsum: begin
                        if (accept) begin
                            cmd_op    <= op_sh[1:0];
                            cmd_addr  <= addr_sh;
                            cmd_data  <= data_sh;
                            cmd_valid <= 1'b1;
                            state     <= StIssue;
                        end
                    end
                    StIssue: begin
                        if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            ok_cnt    <= ok_cnt + 8'd1;
                            state     <= StHunt;
                        end
                    end
                    default: state <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: doc/dds_frame_parser.md
Name: dds_frame_parser

Overview:
- Sits between the UART receive FIFO output and the DDS controller's register-access request path.
- Consumes a raw byte stream and assembles fixed 8-byte command frames.
- Validates the sync byte, opcode and checksum, then presents one decoded command (opcode, 8-bit register address, 32-bit data) to the controller over a valid/ready handshake.
- Drops malformed or stalled frames and reports why.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker.
- TIMEOUT_CYCLES, 500000, maximum clk cycles allowed between consecutive bytes inside a frame.
- TO_W, 20, width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  incoming byte.
- byte_ready  output  1  parser accepts the byte this cycle.
- cmd_valid  output  1  decoded command available.
- cmd_ready  input  1  controller takes the command.
- cmd_op  output  2  01 = register write, 10 = register read.
- cmd_addr  output  8  DDS register address.
- cmd_data  output  32  write data, MSB first on the wire; don't-care for reads.
- err_pulse  output  1  one-cycle pulse when a frame is dropped.
- err_code  output  2  01 = checksum, 10 = timeout, 11 = bad opcode; held until the next err_pulse.
- ok_cnt  output  8  count of issued frames; wraps.
- err_cnt  output  8  count of dropped frames; wraps.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it overrides every other input in the same cycle.
- Reset values:
  - State = HUNT; byte_ready = 1.
  - cmd_valid, err_pulse = 0.
  - err_code, cmd_op, cmd_addr, cmd_data, ok_cnt, err_cnt = 0.
  - Timeout counter = 0.
- Frame format, 8 bytes: SYNC, OP, ADDR, D3, D2, D1, D0, CSUM.
  - CSUM = XOR of OP, ADDR, D3, D2, D1, D0.
  - OP byte values: 8'h01 = write, 8'h02 = read. Every other value is a bad opcode.
- Handshake: a byte is accepted on any cycle where byte_valid and byte_ready are both 1.
  - byte_ready = 1 in every state except ISSUE.
  - While not ready, the upstream source holds its byte.
- States and transitions:
  - HUNT: an accepted byte equal to SYNC_BYTE goes to OP. Any other byte is discarded silently (no error).
  - OP, ADDR, D3, D2, D1, D0: each accepted byte is stored in a shadow register and the state advances. A byte equal to SYNC_BYTE is treated as ordinary data here.
  - CSUM, on an accepted byte:
    - Checksum mismatch: go to HUNT, err_code = 01. Checksum takes priority over opcode.
    - Checksum matches but OP is bad: go to HUNT, err_code = 11.
    - Otherwise: load cmd_op, cmd_addr and cmd_data from the shadow registers, set cmd_valid = 1 on the next cycle, go to ISSUE.
  - ISSUE: cmd_valid held at 1 and all cmd_* outputs held stable until cmd_ready = 1. On that cycle: cmd_valid = 0 next cycle, ok_cnt increments, go to HUNT.
- Latency: cmd_valid rises exactly 1 cycle after the CSUM byte is accepted. Best-case throughput is one frame per 9 cycles (8 bytes plus 1 issue cycle, with cmd_ready tied high).
- Timeout:
  - Counter runs only in OP through CSUM.
  - Cleared on every accepted byte and on entering HUNT.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted: go to HUNT, err_code = 10.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and no timeout occurs.
  - The counter is held at 0 in HUNT and ISSUE, so the controller may stall indefinitely.
- Errors: every drop produces one err_pulse and increments err_cnt by exactly 1. Simultaneous causes are impossible by construction.
- Shadow registers are never exposed. cmd_* change only on entry to ISSUE.
- Reset mid-frame or mid-ISSUE: partial frame is discarded, cmd_valid drops on the next edge, no error is reported, counters clear.

Test Plan:
- Write frame 55 01 0E 12 34 56 78 07 streamed back-to-back, cmd_ready = 1 → cmd_valid high exactly 1 cycle after CSUM; cmd_op = 01, cmd_addr = 0E, cmd_data = 12345678; ok_cnt = 1; err_pulse never asserts.
- Same frame with CSUM = 08 → no cmd_valid; one err_pulse with err_code = 01; err_cnt = 1. A following valid frame is then decoded correctly.
- Garbage 00 FF 55 02 01 00 00 00 00 03 with cmd_ready = 0 for 20 cycles → 00 and FF dropped silently; cmd_op = 10, cmd_addr = 01; cmd_valid and outputs stable for 20 cycles; byte_ready = 0 throughout; ok_cnt increments on the cmd_ready cycle.
- TIMEOUT_CYCLES = 16: send 55 01 then idle → err_pulse with err_code = 10, state back to HUNT. Separately, a byte arriving on cycle 15 of the gap → no timeout.
- Frame 55 07 00 00 00 00 00 07 → err_code = 11, no command issued. Assert rst during ADDR of the next frame → outputs and counters return to 0, then the next valid frame decodes.
